hazard_tracker: RTL and testbench

Pipeline hazard unit for the five-stage MIPS core. It is the consumer of the per-instruction hazard descriptors the decoder produces in D: write address, write enable, T_new, T_use_rs and T_use_rt. It keeps a shadow of every in-flight writer in E, M and W, counts each writer's T_new down as it advances, and drives the D-stage stall/bubble plus every forwarding-mux select in D, E and M.

---
 rtl/hazard_tracker.sv | 103 ++++++++++
 tb/tb_hazard_tracker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Hazard unit for the five-stage MIPS core: shadows in-flight writers in E/M/W,
// derives the D-stage stall and every forwarding select from their T_new.
module hazard_tracker (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [2:0] D_T_use_rs,
  input  logic [2:0] D_T_use_rt,
  input  logic [4:0] D_Addr_W,
  input  logic       D_WriteEn,
  input  logic [2:0] D_T_new,
  output logic       stall,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt,
  output logic [1:0] fwd_M_rt
);

  logic [4:0] r_e_addr, r_e_rs, r_e_rt;
  logic       r_e_we;
  logic [2:0] r_e_tnew;
  logic [4:0] r_m_addr, r_m_rt;
  logic       r_m_we;
  logic [2:0] r_m_tnew;
  logic [4:0] r_w_addr;
  logic       r_w_we;
  logic [2:0] r_w_tnew;

  logic [2:0] w_d_rs, w_d_rt;

  function automatic logic [2:0] dec_sat(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

  function automatic logic hit(input logic we, input logic [4:0] addr, input logic [4:0] r);
    return we && (r != 5'd0) && (addr == r);
  endfunction

  // Youngest matching slot decides both stall and select; an older producer
  // behind a still-pending younger writer is never used.
  function automatic logic [2:0] d_src(input logic he, input logic hm, input logic hw,
                                       input logic [2:0] te, input logic [2:0] tm,
                                       input logic [2:0] tw, input logic [2:0] tuse);
    logic [2:0] res;
    res = 3'b000;
    if (he)      res = {te > tuse, (te == 3'd0) ? 2'd1 : 2'd0};
    else if (hm) res = {tm > tuse, (tm == 3'd0) ? 2'd2 : 2'd0};
    else if (hw) res = {tw > tuse, (tw == 3'd0) ? 2'd3 : 2'd0};
    return res;
  endfunction

  function automatic logic [1:0] down_src(input logic hm, input logic hw,
                                          input logic [2:0] tm, input logic [2:0] tw);
    logic [1:0] sel;
    sel = 2'd0;
    if (hm)      sel = (tm == 3'd0) ? 2'd2 : 2'd0;
    else if (hw) sel = (tw == 3'd0) ? 2'd3 : 2'd0;
    return sel;
  endfunction

  always_comb begin
    w_d_rs = d_src(hit(r_e_we, r_e_addr, D_rs), hit(r_m_we, r_m_addr, D_rs),
                   hit(r_w_we, r_w_addr, D_rs), r_e_tnew, r_m_tnew, r_w_tnew, D_T_use_rs);
    w_d_rt = d_src(hit(r_e_we, r_e_addr, D_rt), hit(r_m_we, r_m_addr, D_rt),
                   hit(r_w_we, r_w_addr, D_rt), r_e_tnew, r_m_tnew, r_w_tnew, D_T_use_rt);
    stall    = w_d_rs[2] | w_d_rt[2];
    fwd_D_rs = w_d_rs[1:0];
    fwd_D_rt = w_d_rt[1:0];
    fwd_E_rs = down_src(hit(r_m_we, r_m_addr, r_e_rs), hit(r_w_we, r_w_addr, r_e_rs),
                        r_m_tnew, r_w_tnew);
    fwd_E_rt = down_src(hit(r_m_we, r_m_addr, r_e_rt), hit(r_w_we, r_w_addr, r_e_rt),
                        r_m_tnew, r_w_tnew);
    fwd_M_rt = (hit(r_w_we, r_w_addr, r_m_rt) && (r_w_tnew == 3'd0)) ? 2'd3 : 2'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_addr <= '0; r_e_we <= 1'b0; r_e_tnew <= '0; r_e_rs <= '0; r_e_rt <= '0;
      r_m_addr <= '0; r_m_we <= 1'b0; r_m_tnew <= '0; r_m_rt <= '0;
      r_w_addr <= '0; r_w_we <= 1'b0; r_w_tnew <= '0;
    end else begin
      if (stall) begin
        r_e_addr <= '0; r_e_we <= 1'b0; r_e_tnew <= '0; r_e_rs <= '0; r_e_rt <= '0;
      end else begin
        r_e_addr <= D_Addr_W;
        r_e_we   <= D_WriteEn;
        r_e_tnew <= dec_sat(D_T_new);
        r_e_rs   <= D_rs;
        r_e_rt   <= D_rt;
      end
      r_m_addr <= r_e_addr;
      r_m_we   <= r_e_we;
      r_m_tnew <= dec_sat(r_e_tnew);
      r_m_rt   <= r_e_rt;
      r_w_addr <= r_m_addr;
      r_w_we   <= r_m_we;
      r_w_tnew <= dec_sat(r_m_tnew);
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: the bench acts as the F/D stage, pushes the
// hand-derived expected outputs per cycle to a scoreboard and checks them.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] D_rs, D_rt, D_Addr_W;
  logic [2:0] D_T_use_rs, D_T_use_rt, D_T_new;
  logic       D_WriteEn;
  logic       stall;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

  hazard_tracker dut (
    .clk(clk), .reset_n(reset_n),
    .D_rs(D_rs), .D_rt(D_rt), .D_T_use_rs(D_T_use_rs), .D_T_use_rt(D_T_use_rt),
    .D_Addr_W(D_Addr_W), .D_WriteEn(D_WriteEn), .D_T_new(D_T_new),
    .stall(stall), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs; logic [2:0] urs; logic [4:0] rt; logic [2:0] urt;
    logic [4:0] aw; logic we; logic [2:0] tn;
  } ins_t;

  typedef struct {
    string tag; logic st; logic [1:0] fdrs, fdrt, fers, fert, fmrt;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic ins_t mk(int rs, int urs, int rt, int urt, int aw, int we, int tn);
    ins_t i;
    i.rs = 5'(rs); i.urs = 3'(urs); i.rt = 5'(rt); i.urt = 3'(urt);
    i.aw = 5'(aw); i.we = 1'(we); i.tn = 3'(tn);
    return i;
  endfunction

  function automatic exp_t ex(string tag, int st, int a, int b, int c, int d, int e);
    exp_t x;
    x.tag = tag; x.st = 1'(st);
    x.fdrs = 2'(a); x.fdrt = 2'(b); x.fers = 2'(c); x.fert = 2'(d); x.fmrt = 2'(e);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".stall"},    {1'b0, stall}, {1'b0, e.st});
      chk({e.tag, ".fwd_D_rs"}, fwd_D_rs, e.fdrs);
      chk({e.tag, ".fwd_D_rt"}, fwd_D_rt, e.fdrt);
      chk({e.tag, ".fwd_E_rs"}, fwd_E_rs, e.fers);
      chk({e.tag, ".fwd_E_rt"}, fwd_E_rt, e.fert);
      chk({e.tag, ".fwd_M_rt"}, fwd_M_rt, e.fmrt);
    end
  endtask

  task automatic drive(input ins_t i);
    D_rs = i.rs; D_T_use_rs = i.urs; D_rt = i.rt; D_T_use_rt = i.urt;
    D_Addr_W = i.aw; D_WriteEn = i.we; D_T_new = i.tn;
  endtask

  // One pipeline cycle: drive D mid-cycle, record expectation, sample 1ns later.
  task automatic step(input ins_t i, input exp_t e);
    @(negedge clk);
    drive(i);
    sb.push_back(e);
    #1;
    check_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    ins_t nop;
    nop = mk(0, 5, 0, 5, 0, 0, 0);

    reset_n = 1'b0;
    drive(mk(3, 0, 4, 0, 3, 1, 3));
    #2;
    sb.push_back(ex("rst_hold", 0, 0, 0, 0, 0, 0));
    check_front();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Writer of $3 in flight, then reset with a reader of $3 in D
    step(mk(1, 1, 0, 5, 3, 1, 3), ex("pre_rst_lw3", 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b0;
    drive(mk(3, 0, 3, 0, 0, 0, 0));
    sb.push_back(ex("rst_clears", 0, 0, 0, 0, 0, 0));
    #1;
    check_front();
    @(negedge clk);
    reset_n = 1'b1;

    step(mk(1, 1, 2, 1, 10, 1, 2), ex("indep1", 0, 0, 0, 0, 0, 0));
    step(mk(3, 1, 4, 1, 11, 1, 2), ex("indep2", 0, 0, 0, 0, 0, 0));
    step(mk(5, 1, 6, 1, 12, 1, 2), ex("indep3", 0, 0, 0, 0, 0, 0));
    repeat (3) step(nop, ex("flush0", 0, 0, 0, 0, 0, 0));

    // Load-use: lw $8 ; add $9,$8,$8
    step(mk(1, 1, 0, 5, 8, 1, 3), ex("lu_lw", 0, 0, 0, 0, 0, 0));
    step(mk(8, 1, 8, 1, 9, 1, 2), ex("lu_stall", 1, 0, 0, 0, 0, 0));
    step(mk(8, 1, 8, 1, 9, 1, 2), ex("lu_go", 0, 0, 0, 0, 0, 0));
    step(nop, ex("lu_fwdE", 0, 0, 0, 3, 3, 0));
    step(nop, ex("lu_tail1", 0, 0, 0, 0, 0, 0));
    step(nop, ex("lu_tail2", 0, 0, 0, 0, 0, 0));

    // add $5 ; beq $5,$0 ; lw $6 ; beq $6,$0
    step(mk(1, 1, 2, 1, 5, 1, 2), ex("br_add", 0, 0, 0, 0, 0, 0));
    step(mk(5, 0, 0, 0, 0, 0, 0), ex("br_stall", 1, 0, 0, 0, 0, 0));
    step(mk(5, 0, 0, 0, 0, 0, 0), ex("br_fwdM", 0, 2, 0, 0, 0, 0));
    step(mk(1, 1, 0, 5, 6, 1, 3), ex("br_lw6", 0, 0, 0, 3, 0, 0));
    step(mk(6, 0, 0, 0, 0, 0, 0), ex("lwbr_st1", 1, 0, 0, 0, 0, 0));
    step(mk(6, 0, 0, 0, 0, 0, 0), ex("lwbr_st2", 1, 0, 0, 0, 0, 0));
    step(mk(6, 0, 0, 0, 0, 0, 0), ex("lwbr_fwdW", 0, 3, 0, 0, 0, 0));
    repeat (3) step(nop, ex("flush1", 0, 0, 0, 0, 0, 0));

    // ori $4 ; add $4 ; beq $4 : younger pending writer blocks M
    step(mk(0, 1, 0, 5, 4, 1, 2), ex("pr_ori", 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 2, 1, 4, 1, 2), ex("pr_add", 0, 0, 0, 0, 0, 0));
    step(mk(4, 0, 0, 0, 0, 0, 0), ex("pr_block", 1, 0, 0, 0, 0, 0));
    step(mk(4, 0, 0, 0, 0, 0, 0), ex("pr_fwdM", 0, 2, 0, 0, 0, 0));
    step(nop, ex("pr_fwdE", 0, 0, 0, 3, 0, 0));
    repeat (2) step(nop, ex("flush2", 0, 0, 0, 0, 0, 0));

    // Writer claiming $0 is never a producer
    step(mk(1, 1, 0, 5, 0, 1, 3), ex("z_wr0", 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0), ex("z_rd0", 0, 0, 0, 0, 0, 0));
    step(nop, ex("z_e1", 0, 0, 0, 0, 0, 0));
    step(nop, ex("z_e2", 0, 0, 0, 0, 0, 0));
    step(nop, ex("z_e3", 0, 0, 0, 0, 0, 0));

    // lw $7 ; sw $7 : data reaches the store in M from W
    step(mk(1, 1, 0, 5, 7, 1, 3), ex("st_lw", 0, 0, 0, 0, 0, 0));
    step(mk(2, 1, 7, 2, 0, 0, 0), ex("st_sw", 0, 0, 0, 0, 0, 0));
    step(nop, ex("st_inE", 0, 0, 0, 0, 0, 0));
    step(nop, ex("st_fwdM", 0, 0, 0, 0, 0, 3));
    step(nop, ex("st_tail", 0, 0, 0, 0, 0, 0));

    // add $7 ; nop ; sw $7
    step(mk(1, 1, 2, 1, 7, 1, 2), ex("sv_add", 0, 0, 0, 0, 0, 0));
    step(nop, ex("sv_nop", 0, 0, 0, 0, 0, 0));
    step(mk(2, 1, 7, 2, 0, 0, 0), ex("sv_sw", 0, 0, 2, 0, 0, 0));
    step(nop, ex("sv_fwdE", 0, 0, 0, 0, 3, 0));
    step(nop, ex("sv_noM", 0, 0, 0, 0, 0, 0));
    repeat (2) step(nop, ex("flush3", 0, 0, 0, 0, 0, 0));

    // Async reset during the second stall cycle of lw -> beq
    step(mk(1, 1, 0, 5, 6, 1, 3), ex("ar_lw", 0, 0, 0, 0, 0, 0));
    step(mk(6, 0, 0, 0, 0, 0, 0), ex("ar_st1", 1, 0, 0, 0, 0, 0));
    step(mk(6, 0, 0, 0, 0, 0, 0), ex("ar_st2", 1, 0, 0, 0, 0, 0));
    #1;
    reset_n = 1'b0;
    sb.push_back(ex("ar_drop", 0, 0, 0, 0, 0, 0));
    #1;
    check_front();
    @(negedge clk);
    reset_n = 1'b1;
    step(mk(6, 0, 0, 0, 0, 0, 0), ex("ar_after", 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
